// File: rtl/spi_register_bank_if.sv
// Byte-level bus between the SPI slave / fabric and the register bank.
// The master side is the SPI slave plus the fabric. The slave side is the bank.
interface spi_register_bank_if #(
    parameter int DEPTH = 16
);
    logic                 Active_i;
    logic [7:0]           RxData_i;
    logic                 RxDone_i;
    logic [7:0]           TxData_o;
    logic [8*DEPTH-1:0]   Regs_o;
    logic                 WriteStrobe_o;
    logic [6:0]           WriteAddr_o;
    logic                 LocalWrite_i;
    logic [6:0]           LocalAddr_i;
    logic [7:0]           LocalData_i;

    modport master (
        output Active_i, RxData_i, RxDone_i, LocalWrite_i, LocalAddr_i, LocalData_i,
        input  TxData_o, Regs_o, WriteStrobe_o, WriteAddr_o
    );

    modport slave (
        input  Active_i, RxData_i, RxDone_i, LocalWrite_i, LocalAddr_i, LocalData_i,
        output TxData_o, Regs_o, WriteStrobe_o, WriteAddr_o
    );
endinterface

// File: rtl/spi_register_bank.sv
// SPI command decoder and register file.
// The first byte of each frame is a command: bit 7 selects read (1) or write (0),
// and bits 6:0 give the start address. The following bytes auto-increment through
// the bank, and the pointer wraps inside the bank. The fabric has its own write
// port. An SPI write has priority over a fabric write on an address collision.
module spi_register_bank #(
    parameter int         DEPTH  = 16,
    parameter logic [7:0] STATUS = 8'hA5
) (
    input  logic                 Clock,
    input  logic                 Reset,
    spi_register_bank_if.slave   Bus_io
);
    localparam int         AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [7:0] DEPTH8 = 8'(DEPTH);
    localparam logic [6:0] LAST   = 7'(DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CMD     = 3'd1,
        WRITE   = 3'd2,
        READ    = 3'd3,
        DISCARD = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [6:0]  ptr_q, ptr_d;
    logic [7:0]  tx_q, tx_d;
    logic        strobe_q, strobe_d;
    logic [6:0]  waddr_q, waddr_d;
    logic        spi_we;
    logic [7:0]  regs_q [DEPTH];

    logic [6:0]  cmd_addr;
    logic        cmd_in_range;

    assign cmd_addr     = Bus_io.RxData_i[6:0];
    assign cmd_in_range = ({1'b0, cmd_addr} < DEPTH8);

    function automatic logic [6:0] inc(input logic [6:0] p);
        return (p == LAST) ? 7'd0 : p + 7'd1;
    endfunction

    // State register.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state. Dropping Active aborts a frame from any state.
    always_comb begin
        state_d = state_q;
        if (!Bus_io.Active_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: state_d = CMD;
                CMD: begin
                    if (Bus_io.RxDone_i) begin
                        if (!cmd_in_range)            state_d = DISCARD;
                        else if (Bus_io.RxData_i[7])  state_d = READ;
                        else                          state_d = WRITE;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Datapath next values: MISO byte, pointer, write strobe and write address.
    always_comb begin
        tx_d     = tx_q;
        ptr_d    = ptr_q;
        strobe_d = 1'b0;
        waddr_d  = waddr_q;
        spi_we   = 1'b0;
        if (!Bus_io.Active_i) begin
            tx_d = STATUS;
        end else begin
            case (state_q)
                IDLE: tx_d = STATUS;
                CMD: begin
                    if (Bus_io.RxDone_i) begin
                        if (!cmd_in_range) begin
                            tx_d = 8'h00;
                        end else if (Bus_io.RxData_i[7]) begin
                            tx_d  = regs_q[cmd_addr[AW-1:0]];
                            ptr_d = inc(cmd_addr);
                        end else begin
                            ptr_d = cmd_addr;
                        end
                    end
                end
                WRITE: begin
                    if (Bus_io.RxDone_i) begin
                        spi_we   = 1'b1;
                        strobe_d = 1'b1;
                        waddr_d  = ptr_q;
                        ptr_d    = inc(ptr_q);
                    end
                end
                READ: begin
                    if (Bus_io.RxDone_i) begin
                        tx_d  = regs_q[ptr_q[AW-1:0]];
                        ptr_d = inc(ptr_q);
                    end
                end
                DISCARD: tx_d = 8'h00;
                default: tx_d = tx_q;
            endcase
        end
    end

    // Registered outputs and the pointer.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            ptr_q    <= 7'd0;
            tx_q     <= STATUS;
            strobe_q <= 1'b0;
            waddr_q  <= 7'd0;
        end else begin
            ptr_q    <= ptr_d;
            tx_q     <= tx_d;
            strobe_q <= strobe_d;
            waddr_q  <= waddr_d;
        end
    end

    // Register file. An SPI write beats a fabric write to the same address.
    // Fabric addresses past the bank match no entry, so those writes are dropped.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= 8'h00;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (spi_we && ptr_q == 7'(i))
                    regs_q[i] <= Bus_io.RxData_i;
                else if (Bus_io.LocalWrite_i && Bus_io.LocalAddr_i == 7'(i))
                    regs_q[i] <= Bus_io.LocalData_i;
            end
        end
    end

    assign Bus_io.TxData_o      = tx_q;
    assign Bus_io.WriteStrobe_o = strobe_q;
    assign Bus_io.WriteAddr_o   = waddr_q;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_regs_out
            assign Bus_io.Regs_o[8*gi +: 8] = regs_q[gi];
        end
    endgenerate
endmodule
